// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed 7-segment display driver. A prescaler divides clk_i
//   into digit slots of SCAN_DIV cycles; a digit index walks 0..DIGITS-1 and
//   the selected digit's code is decoded onto shared segment lines.
//   New display data is captured into a pending register by load_i and is
//   only promoted to the displayed (shadow) register at a frame boundary,
//   so a frame is never shown half old / half new.
//
//   Build option: define SEG_HEX_EN to decode codes 10..15 as A b C d E F;
//   when undefined those codes show a dark digit.
//
// Ports
//   clk_i    : clock, all state on rising edge
//   rst_i    : synchronous active-high reset
//   sym_i    : 4 bits per digit, digit k = sym_i[4k+3:4k], digit 0 rightmost
//   dp_i     : decimal-point request per digit, 1 = lit
//   load_i   : one-cycle strobe capturing sym_i / dp_i
//   blank_i  : level, 1 = display dark (scanning keeps running)
//   led_o    : segments a..g on [7:1] (a = bit 7), active-low, registered
//   dp_o     : decimal-point segment, active-low, registered
//   an_o     : digit enables, active-low one-cold, registered
//   frame_o  : one-cycle pulse in each frame-boundary cycle
module seg_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [4*DIGITS-1:0]   sym_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic                  load_i,
   input  logic                  blank_i,
   output logic [7:1]            led_o,
   output logic                  dp_o,
   output logic [DIGITS-1:0]     an_o,
   output logic                  frame_o
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [PW-1:0]          pre_q, pre_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [4*DIGITS-1:0]    shd_sym_q, shd_sym_d;
   logic [DIGITS-1:0]      shd_dp_q, shd_dp_d;
   logic [4*DIGITS-1:0]    pnd_sym_q, pnd_sym_d;
   logic [DIGITS-1:0]      pnd_dp_q, pnd_dp_d;
   logic                   pnd_vld_q, pnd_vld_d;
   logic [7:1]             led_q, led_d;
   logic                   dp_q, dp_d;
   logic [DIGITS-1:0]      an_q, an_d;

   logic                   tick;
   logic                   boundary;
   logic [3:0]             cur_code;
   logic                   cur_dp;

   // abcdefg, active-low
   function automatic logic [7:1] seg_decode(input logic [3:0] code);
      logic [7:1] s;
      case (code)
         4'd0: s = 7'b0000001;
         4'd1: s = 7'b1001111;
         4'd2: s = 7'b0010010;
         4'd3: s = 7'b0000110;
         4'd4: s = 7'b1001100;
         4'd5: s = 7'b0100100;
         4'd6: s = 7'b0100000;
         4'd7: s = 7'b0001111;
         4'd8: s = 7'b0000000;
         4'd9: s = 7'b0000100;
`ifdef SEG_HEX_EN
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;   // 4'hF
`else
         default: s = 7'b1111111;
`endif
      endcase
      return s;
   endfunction

   always_comb begin
      tick     = (pre_q == PRE_LAST);
      boundary = tick && (idx_q == IDX_LAST);

      pre_d = tick ? '0 : pre_q + PW'(1);
      idx_d = idx_q;
      if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

      // Pending capture: a boundary always drains the pending slot. A load in
      // the boundary cycle bypasses pending and goes straight to the shadow.
      shd_sym_d = shd_sym_q;
      shd_dp_d  = shd_dp_q;
      pnd_sym_d = pnd_sym_q;
      pnd_dp_d  = pnd_dp_q;
      pnd_vld_d = pnd_vld_q;
      if (boundary) begin
         if (load_i) begin
            shd_sym_d = sym_i;
            shd_dp_d  = dp_i;
         end else if (pnd_vld_q) begin
            shd_sym_d = pnd_sym_q;
            shd_dp_d  = pnd_dp_q;
         end
         pnd_vld_d = 1'b0;
      end else if (load_i) begin
         pnd_sym_d = sym_i;
         pnd_dp_d  = dp_i;
         pnd_vld_d = 1'b1;
      end

      // Digit select by compare avoids a variable-width index multiply.
      cur_code = 4'd0;
      cur_dp   = 1'b0;
      an_d     = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            cur_code = shd_sym_q[4*k +: 4];
            cur_dp   = shd_dp_q[k];
            an_d[k]  = 1'b0;
         end
      end

      led_d = seg_decode(cur_code);
      dp_d  = ~cur_dp;
      if (blank_i) begin
         led_d = '1;
         dp_d  = 1'b1;
         an_d  = '1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_q     <= '0;
         idx_q     <= '0;
         shd_sym_q <= '0;
         shd_dp_q  <= '0;
         pnd_sym_q <= '0;
         pnd_dp_q  <= '0;
         pnd_vld_q <= 1'b0;
         led_q     <= '1;
         dp_q      <= 1'b1;
         an_q      <= '1;
      end else begin
         pre_q     <= pre_d;
         idx_q     <= idx_d;
         shd_sym_q <= shd_sym_d;
         shd_dp_q  <= shd_dp_d;
         pnd_sym_q <= pnd_sym_d;
         pnd_dp_q  <= pnd_dp_d;
         pnd_vld_q <= pnd_vld_d;
         led_q     <= led_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
      end
   end

   assign led_o   = led_q;
   assign dp_o    = dp_q;
   assign an_o    = an_q;
   // Gated by rst_i so no pulse escapes in a cycle where reset is asserted.
   assign frame_o = boundary & ~rst_i;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, meaning number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, meaning clk_i cycles per digit slot; legal range >= 2.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 sym_i  input  4*DIGITS  digit codes; digit k is sym_i[4k+3:4k], and digit 0 is the rightmost.
REQ-006 dp_i  input  DIGITS  decimal-point request per digit, 1 = lit.
REQ-007 load_i  input  1  one-cycle strobe that captures sym_i and dp_i.
REQ-008 blank_i  input  1  level; 1 = display dark, scanning continues.
REQ-009 led_o  output  7  segments a..g on bits [7:1], a = bit 7, active-low (0 = lit).
REQ-010 dp_o  output  1  decimal-point segment, active-low.
REQ-011 an_o  output  DIGITS  digit enables, active-low, one-cold; bit k selects digit k.
REQ-012 frame_o  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick = prescaler at SCAN_DIV-1.
REQ-014 Digit index SHALL advance by 1 on each tick and wrap from DIGITS-1 to 0.
- Frame boundary = tick while index = DIGITS-1.
REQ-015 frame_o SHALL be 1 exactly in frame-boundary cycles.
REQ-016 load_i SHALL copy sym_i/dp_i into a pending register and set a pending flag.
- Multiple loads within one frame: the last one wins.
REQ-017 At a frame boundary the shadow (displayed) register SHALL take the data:
- from sym_i/dp_i if load_i = 1 in that same cycle;
- otherwise from the pending register if the flag is set;
- the pending flag is then cleared.
- The shadow SHALL never change outside a boundary, so no frame tears.
REQ-018 led_o, dp_o and an_o SHALL be registered, reflecting the index and shadow of the previous cycle (latency 1 clk).
REQ-019 Decode codes 0..9 (abcdefg, active-low):
- 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
- 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
REQ-020 Codes 10..15 SHALL decode to 1111111 unless SEG_HEX_EN is defined (REQ-025).
REQ-021 dp_o SHALL be the inverse of the shadow dp bit of the selected digit.
REQ-022 blank_i = 1 SHALL force an_o, led_o and dp_o to all ones, registered like REQ-018.
- Prescaler, index, frame_o and load handling continue unaffected.

Reset
REQ-023 While rst_i = 1 the block SHALL set:
- prescaler = 0, index = 0
- shadow sym = 0 and shadow dp = 0; pending register and pending flag cleared
- led_o = 1111111, dp_o = 1, an_o = all ones, frame_o = 0
REQ-024 Reset asserted mid-frame SHALL discard pending data and restart scanning at digit 0 with prescaler 0.
- First non-blank output appears one cycle after rst_i falls.

Configuration
REQ-025 Macro SEG_HEX_EN.
- Defined: codes 10..15 decode as A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- Undefined: codes 10..15 decode as 1111111.
- All other behaviour is identical in both builds.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-026 Reset, then release -> outputs blank during reset; 1 cycle after release an_o = 1110, led_o = 0000001, dp_o = 1.
REQ-027 Free run -> an_o steps 1110, 1101, 1011, 0111, each held 4 clk; frame_o pulses every 16 clk, in the last cycle of the 0111 slot's index.
REQ-028 load_i with sym_i = 16'h1234, dp_i = 0010, mid-frame -> display unchanged until the next frame_o.
- Then: digit0 led_o = 1001100, digit1 = 0000110 with dp_o = 0, digit2 = 0010010, digit3 = 1001111.
REQ-029 Two loads, 16'h1111 then 16'h5678, in one frame -> after the boundary, 5678 is displayed.
- load_i of 16'h9999 in the boundary cycle itself -> 9999 is displayed after that boundary.
REQ-030 sym_i digit0 = 4'hA -> led_o = 1111111 without SEG_HEX_EN; 0001000 with it.
REQ-031 blank_i = 1 for 20 clk -> an_o = 1111, led_o = 1111111, dp_o = 1 throughout; frame_o keeps its 16-clk period.
- rst_i pulsed mid-frame with a pending load -> pending data is never displayed.
